// File: rtl/sign_extend.sv
// -----------------------------------------------------------------------------
// sign_extend
//
// Purpose:
//   Decodes the opcode of a 16-bit instruction word, selects the immediate
//   field it carries (4, 8 or 12 bits, or none), sign-extends that field to
//   16 bits by replicating its MSB, and registers the result together with a
//   format code. The block has a fixed latency of one cycle. It has no stall
//   and no enable.
//
// Ports:
//   clk                    in   1   single clock, rising-edge active
//   rst                    in   1   synchronous, active-high reset
//   instruction            in  16   instruction word, opcode = [15:12]
//   signExtendedImmediate  out 16   registered sign-extended immediate
//   immFormat              out  2   registered format: 0 none, 1 imm4,
//                                   2 imm8, 3 imm12
// -----------------------------------------------------------------------------
module sign_extend (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] instruction,
    output logic [15:0] signExtendedImmediate,
    output logic [1:0]  immFormat
);

    localparam logic [1:0] FMT_NONE  = 2'd0;
    localparam logic [1:0] FMT_IMM4  = 2'd1;
    localparam logic [1:0] FMT_IMM8  = 2'd2;
    localparam logic [1:0] FMT_IMM12 = 2'd3;

    logic [3:0]  opcode;
    logic [1:0]  fmt_next;
    logic [15:0] imm_next;

    assign opcode = instruction[15:12];

    // The format depends only on the opcode. The operand bits never steer
    // the selection.
    always_comb begin
        fmt_next = FMT_NONE;
        unique case (opcode)
            4'h4, 4'h5:                         fmt_next = FMT_IMM4;
            4'h6, 4'h7, 4'h8, 4'h9, 4'hA, 4'hB: fmt_next = FMT_IMM8;
            4'hC, 4'hD:                         fmt_next = FMT_IMM12;
            default:                            fmt_next = FMT_NONE;
        endcase
    end

    // The extension copies the field MSB into the upper bits. No arithmetic
    // is involved. Bits outside the selected field are dropped.
    always_comb begin
        imm_next = 16'h0000;
        unique case (fmt_next)
            FMT_IMM4:  imm_next = {{12{instruction[3]}},  instruction[3:0]};
            FMT_IMM8:  imm_next = {{8{instruction[7]}},   instruction[7:0]};
            FMT_IMM12: imm_next = {{4{instruction[11]}},  instruction[11:0]};
            default:   imm_next = 16'h0000;
        endcase
    end

    // The outputs come straight from flops, so they stay glitch-free. Reset
    // wins over the sampled word, which keeps X/Z on instruction away from
    // the outputs while rst is high.
    always_ff @(posedge clk) begin
        if (rst) begin
            signExtendedImmediate <= 16'h0000;
            immFormat             <= FMT_NONE;
        end else begin
            signExtendedImmediate <= imm_next;
            immFormat             <= fmt_next;
        end
    end

endmodule

// File: tb/tb_sign_extend.sv
// -----------------------------------------------------------------------------
// tb_sign_extend
//
// Directed and random stimulus for sign_extend. Each driven word pushes its
// expected output onto a scoreboard queue. One cycle later, after the
// capturing edge, the entry is popped and compared with the DUT outputs.
// -----------------------------------------------------------------------------
module tb_sign_extend;

    logic        clk;
    logic        rst;
    logic [15:0] instruction;
    logic [15:0] signExtendedImmediate;
    logic [1:0]  immFormat;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [15:0] imm;
        logic [1:0]  fmt;
        string       tag;
    } exp_t;

    exp_t sb[$];

    sign_extend dut (
        .clk                   (clk),
        .rst                   (rst),
        .instruction           (instruction),
        .signExtendedImmediate (signExtendedImmediate),
        .immFormat             (immFormat)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: timeout expired, got no finish, need finish");
        $fatal(1, "watchdog");
    end

    // Reference model. It works through signed integer arithmetic on the
    // field value, not through bit replication.
    function automatic void model(input logic [15:0] ins,
                                  output logic [15:0] imm,
                                  output logic [1:0]  fmt);
        int v;
        v   = 0;
        fmt = 2'd0;
        case (ins[15:12])
            4'h4, 4'h5: begin
                v = int'(ins[3:0]);  if (v >= 8)    v = v - 16;    fmt = 2'd1;
            end
            4'h6, 4'h7, 4'h8, 4'h9, 4'hA, 4'hB: begin
                v = int'(ins[7:0]);  if (v >= 128)  v = v - 256;   fmt = 2'd2;
            end
            4'hC, 4'hD: begin
                v = int'(ins[11:0]); if (v >= 2048) v = v - 4096;  fmt = 2'd3;
            end
            default: begin
                v = 0; fmt = 2'd0;
            end
        endcase
        imm = 16'(v);
    endfunction

    task automatic check();
        exp_t e;
        total++;
        if (sb.size() == 0) begin
            bad++;
            $display("FAIL scoreboard: got empty queue, need an entry");
        end else begin
            e = sb.pop_front();
            assert (signExtendedImmediate === e.imm && immFormat === e.fmt)
            else begin
                bad++;
                $error("FAIL %s: got %h/%0d need %h/%0d", e.tag,
                       signExtendedImmediate, immFormat, e.imm, e.fmt);
            end
        end
    endtask

    // Drives one word for one edge and checks the result that edge produces.
    task automatic step(input logic [15:0] ins, input logic r,
                        input logic [15:0] eimm, input logic [1:0] efmt,
                        input string tag);
        exp_t e;
        @(negedge clk);
        instruction = ins;
        rst         = r;
        e.imm = eimm; e.fmt = efmt; e.tag = tag;
        sb.push_back(e);
        @(posedge clk);
        #1 check();
    endtask

    task automatic step_model(input logic [15:0] ins, input string tag);
        logic [15:0] mi;
        logic [1:0]  mf;
        model(ins, mi, mf);
        step(ins, 1'b0, mi, mf, tag);
    endtask

    initial begin
        logic [15:0] r;
        exp_t        h;
        rst         = 1'b1;
        instruction = 16'h0000;

        // Reset with an unknown instruction word.
        @(negedge clk);
        instruction = 16'hxxxx;
        h.imm = 16'h0000; h.fmt = 2'd0; h.tag = "rst_x";
        sb.push_back(h);
        @(posedge clk);
        #1 check();

        // Hold reset for two edges, then release.
        step(16'hC001, 1'b1, 16'h0000, 2'd0, "rst_c001_a");
        step(16'hC001, 1'b1, 16'h0000, 2'd0, "rst_c001_b");
        step(16'hC001, 1'b0, 16'h0001, 2'd3, "release_c001");

        // Back-to-back mixed formats.
        step(16'hA123, 1'b0, 16'h0023, 2'd2, "seq_a123");
        step(16'hB598, 1'b0, 16'hFF98, 2'd2, "seq_b598");
        step(16'hD698, 1'b0, 16'h0698, 2'd3, "seq_d698");
        step(16'h5123, 1'b0, 16'h0003, 2'd1, "seq_5123");
        step(16'h4598, 1'b0, 16'hFFF8, 2'd1, "seq_4598");
        step(16'h6628, 1'b0, 16'h0028, 2'd2, "seq_6628");
        step(16'h7698, 1'b0, 16'hFF98, 2'd2, "seq_7698");

        // Opcodes that carry no immediate.
        step(16'h0000, 1'b0, 16'h0000, 2'd0, "none_0000");
        step(16'h3FFF, 1'b0, 16'h0000, 2'd0, "none_3fff");
        step(16'hEFFF, 1'b0, 16'h0000, 2'd0, "none_efff");
        step(16'hFFFF, 1'b0, 16'h0000, 2'd0, "none_ffff");

        // Boundaries around each field MSB.
        step(16'h4007, 1'b0, 16'h0007, 2'd1, "bnd_4007");
        step(16'h4008, 1'b0, 16'hFFF8, 2'd1, "bnd_4008");

        // Changing the input between edges must leave the outputs unchanged.
        @(negedge clk);
        instruction = 16'hC7FF;
        #2;
        h.imm = 16'hFFF8; h.fmt = 2'd1; h.tag = "hold_midcycle";
        sb.push_back(h);
        check();

        step(16'h607F, 1'b0, 16'h007F, 2'd2, "bnd_607f");
        step(16'h6080, 1'b0, 16'hFF80, 2'd2, "bnd_6080");
        step(16'hC7FF, 1'b0, 16'h07FF, 2'd3, "bnd_c7ff");
        step(16'hC800, 1'b0, 16'hF800, 2'd3, "bnd_c800");

        // Reset in the middle of a stream drops the word sampled at that edge.
        step(16'hA123, 1'b0, 16'h0023, 2'd2, "mid_a123");
        step(16'hB598, 1'b1, 16'h0000, 2'd0, "mid_rst");
        step(16'h5123, 1'b0, 16'h0003, 2'd1, "mid_5123");

        // Random words checked against the model.
        for (int i = 0; i < 40; i++) begin
            r = 16'($urandom);
            step_model(r, $sformatf("rand_%0d_%h", i, r));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
